// File: rtl/sdram_pkg.sv
// Shared definitions for the closed-page SDRAM command sequencer:
// command encodings, FSM states and width helpers.
package sdram_pkg;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ACT       = 4'd1,
    ST_WAIT_RCD  = 4'd2,
    ST_RW        = 4'd3,
    ST_WAIT_POST = 4'd4,
    ST_PRE       = 4'd5,
    ST_WAIT_RP   = 4'd6,
    ST_REF       = 4'd7,
    ST_WAIT_RFC  = 4'd8
  } state_e;

  // Total width of the packed {bank,row,col} request address.
  function automatic int unsigned addr_w(input int unsigned bank_w,
                                         input int unsigned row_w,
                                         input int unsigned col_w);
    return bank_w + row_w + col_w;
  endfunction

  // Counter width able to hold max_t-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned max_t);
    return (max_t <= 2) ? 1 : $clog2(max_t);
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval counter; expire_c is high for the one
// cycle in which the count sits at zero, after which it reloads.
module sdram_refresh_timer #(
  parameter int unsigned T_REF = 780
) (
  input  logic clk,
  input  logic reset,
  output logic expire_c
);

  localparam int unsigned CW = (T_REF > 1) ? $clog2(T_REF) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q - CW'(1);
    if (cnt_q == '0) cnt_d = CW'(T_REF - 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= CW'(T_REF - 1);
    else       cnt_q <= cnt_d;
  end

  assign expire_c = (cnt_q == '0);

endmodule

// File: rtl/sdram_cmd_sequencer.sv
// Closed-page SDRAM sequencer: ACT -> RD/WR -> PRE per request, periodic
// REF with priority, all timing gaps from one shared down-counter.
module sdram_cmd_sequencer
  import sdram_pkg::*;
#(
  parameter int unsigned T_RCD   = 2,
  parameter int unsigned T_RP    = 2,
  parameter int unsigned T_RFC   = 7,
  parameter int unsigned T_WR    = 2,
  parameter int unsigned CAS_LAT = 2,
  parameter int unsigned T_REF   = 780,
  parameter int unsigned BANK_W  = 2,
  parameter int unsigned ROW_W   = 13,
  parameter int unsigned COL_W   = 9
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_we,
  input  logic [BANK_W+ROW_W+COL_W-1:0]   req_addr,
  output logic [2:0]                      cmd,
  output logic [BANK_W-1:0]               sd_ba,
  output logic [ROW_W-1:0]                sd_addr,
  output logic                            rd_valid,
  output logic                            wr_done,
  output logic                            busy,
  output logic                            ref_miss
);

  localparam int unsigned AW    = addr_w(BANK_W, ROW_W, COL_W);
  localparam int unsigned MAX_A = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int unsigned MAX_B = (T_RFC > T_WR) ? T_RFC : T_WR;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_T = (MAX_C > CAS_LAT) ? MAX_C : CAS_LAT;
  localparam int unsigned DW    = cnt_w(MAX_T);

  state_e              state_q, state_d;
  logic [DW-1:0]       cnt_q, cnt_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic                we_q, we_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [BANK_W-1:0]   ba_q, ba_d;
  logic [ROW_W-1:0]    addr_q, addr_d;
  logic                wr_done_q, wr_done_d;
  logic                busy_q, busy_d;
  logic                ref_pending_q, ref_pending_d;
  logic                ref_miss_q, ref_miss_d;
  logic [CAS_LAT-1:0]  rd_pipe_q;
  logic                enter_rw, enter_pre, enter_idle;
  logic                ref_expire;

  sdram_refresh_timer #(.T_REF(T_REF)) u_refresh_timer (
    .clk      (clk),
    .reset    (reset),
    .expire_c (ref_expire)
  );

  // Commands are issued on the transition into their state, so cmd_q is
  // visible in exactly the cycle the FSM occupies that command's state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bank_d        = bank_q;
    row_d         = row_q;
    col_d         = col_q;
    we_d          = we_q;
    cmd_d         = CMD_NOP;
    ba_d          = '0;
    addr_d        = '0;
    wr_done_d     = 1'b0;
    ref_pending_d = ref_pending_q;
    ref_miss_d    = 1'b0;
    enter_rw      = 1'b0;
    enter_pre     = 1'b0;
    enter_idle    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ref_pending_q) begin
          state_d       = ST_REF;
          cmd_d         = CMD_REF;
          ref_pending_d = 1'b0;
        end else if (req_valid) begin
          bank_d  = req_addr[AW-1 -: BANK_W];
          row_d   = req_addr[COL_W +: ROW_W];
          col_d   = req_addr[COL_W-1:0];
          we_d    = req_we;
          state_d = ST_ACT;
          cmd_d   = CMD_ACT;
          ba_d    = req_addr[AW-1 -: BANK_W];
          addr_d  = req_addr[COL_W +: ROW_W];
        end
      end
      ST_ACT: begin
        cnt_d = DW'(T_RCD - 1);
        if (cnt_d == '0) enter_rw = 1'b1;
        else             state_d  = ST_WAIT_RCD;
      end
      ST_WAIT_RCD: begin
        cnt_d = cnt_q - DW'(1);
        if (cnt_q <= DW'(1)) enter_rw = 1'b1;
      end
      ST_RW: begin
        cnt_d = we_q ? DW'(T_WR - 1) : DW'(CAS_LAT - 1);
        if (cnt_d == '0) enter_pre = 1'b1;
        else             state_d   = ST_WAIT_POST;
      end
      ST_WAIT_POST: begin
        cnt_d = cnt_q - DW'(1);
        if (cnt_q <= DW'(1)) enter_pre = 1'b1;
      end
      ST_PRE: begin
        cnt_d = DW'(T_RP - 1);
        if (cnt_d == '0) enter_idle = 1'b1;
        else             state_d    = ST_WAIT_RP;
      end
      ST_WAIT_RP: begin
        cnt_d = cnt_q - DW'(1);
        if (cnt_q <= DW'(1)) enter_idle = 1'b1;
      end
      ST_REF: begin
        cnt_d = DW'(T_RFC - 1);
        if (cnt_d == '0) enter_idle = 1'b1;
        else             state_d    = ST_WAIT_RFC;
      end
      ST_WAIT_RFC: begin
        cnt_d = cnt_q - DW'(1);
        if (cnt_q <= DW'(1)) enter_idle = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_rw) begin
      state_d   = ST_RW;
      cmd_d     = we_q ? CMD_WR : CMD_RD;
      ba_d      = bank_q;
      addr_d    = ROW_W'(col_q);
      wr_done_d = we_q;
    end
    if (enter_pre) begin
      state_d = ST_PRE;
      cmd_d   = CMD_PRE;
      ba_d    = bank_q;
    end
    if (enter_idle) state_d = ST_IDLE;

    // An expiry while a refresh is still owed is flagged, not queued.
    if (ref_expire) begin
      if (ref_pending_q) ref_miss_d = 1'b1;
      ref_pending_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bank_q        <= '0;
      row_q         <= '0;
      col_q         <= '0;
      we_q          <= 1'b0;
      cmd_q         <= CMD_NOP;
      ba_q          <= '0;
      addr_q        <= '0;
      wr_done_q     <= 1'b0;
      busy_q        <= 1'b0;
      ref_pending_q <= 1'b0;
      ref_miss_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bank_q        <= bank_d;
      row_q         <= row_d;
      col_q         <= col_d;
      we_q          <= we_d;
      cmd_q         <= cmd_d;
      ba_q          <= ba_d;
      addr_q        <= addr_d;
      wr_done_q     <= wr_done_d;
      busy_q        <= busy_d;
      ref_pending_q <= ref_pending_d;
      ref_miss_q    <= ref_miss_d;
    end
  end

  // Read-data strobe pipe runs independently of the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_pipe_q <= '0;
    else       rd_pipe_q <= {rd_pipe_q[CAS_LAT-2:0], (cmd_q == CMD_RD)};
  end

  assign req_ready = (state_q == ST_IDLE) && !ref_pending_q;
  assign cmd       = cmd_q;
  assign sd_ba     = ba_q;
  assign sd_addr   = addr_q;
  assign rd_valid  = rd_pipe_q[CAS_LAT-1];
  assign wr_done   = wr_done_q;
  assign busy      = busy_q;
  assign ref_miss  = ref_miss_q;

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// Bench for sdram_cmd_sequencer: table-driven requests scored through an
// expected-command queue, plus hand-written refresh and reset sequences.
module tb_sdram_cmd_sequencer;

  localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3,
                         PRE = 3'd4, REF = 3'd5;

  logic        clk = 1'b0;
  logic        reset, rm_reset;

  logic        req_valid, req_we, req_ready, rd_valid, wr_done, busy, ref_miss;
  logic [23:0] req_addr;
  logic [2:0]  cmd;
  logic [1:0]  sd_ba;
  logic [12:0] sd_addr;

  logic        r_valid, r_we, r_ready, r_rd_valid, r_wr_done, r_busy, r_ref_miss;
  logic [23:0] r_addr;
  logic [2:0]  r_cmd;
  logic [1:0]  r_ba;
  logic [12:0] r_sd_addr;

  logic        m_valid, m_we, m_ready, m_rd_valid, m_wr_done, m_busy, m_ref_miss;
  logic [23:0] m_addr;
  logic [2:0]  m_cmd;
  logic [1:0]  m_ba;
  logic [12:0] m_sd_addr;

  always #5 clk = ~clk;

  sdram_cmd_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .cmd(cmd), .sd_ba(sd_ba),
    .sd_addr(sd_addr), .rd_valid(rd_valid), .wr_done(wr_done), .busy(busy),
    .ref_miss(ref_miss)
  );

  sdram_cmd_sequencer #(.T_REF(20)) dut_r (
    .clk(clk), .reset(rm_reset), .req_valid(r_valid), .req_ready(r_ready),
    .req_we(r_we), .req_addr(r_addr), .cmd(r_cmd), .sd_ba(r_ba),
    .sd_addr(r_sd_addr), .rd_valid(r_rd_valid), .wr_done(r_wr_done),
    .busy(r_busy), .ref_miss(r_ref_miss)
  );

  sdram_cmd_sequencer #(.T_REF(4), .T_RFC(7)) dut_m (
    .clk(clk), .reset(rm_reset), .req_valid(m_valid), .req_ready(m_ready),
    .req_we(m_we), .req_addr(m_addr), .cmd(m_cmd), .sd_ba(m_ba),
    .sd_addr(m_sd_addr), .rd_valid(m_rd_valid), .wr_done(m_wr_done),
    .busy(m_busy), .ref_miss(m_ref_miss)
  );

  typedef struct {
    int          cyc;
    logic [2:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        wr;
  } ev_t;

  typedef struct {
    logic        fresh;
    logic        b2b_next;
    logic        we;
    logic [1:0]  ba;
    logic [12:0] row;
    logic [8:0]  col;
    logic [2:0]  exp_rw_cmd;
    int          exp_act;
    int          exp_rw;
    int          exp_pre;
    int          exp_rdv;
    int          exp_ready;
  } vec_t;

  ev_t cmdq[$];
  int  rdq[$];
  int  cyc;
  int  passed = 0;
  int  total  = 0;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail(input string name, input longint act, input longint exp);
    total++;
    $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic longint pack_ev(input int c, input logic [2:0] cm, input logic [1:0] b,
                                     input logic [12:0] a, input logic w);
    logic [15:0] c16;
    c16 = c[15:0];
    return 64'({c16, cm, b, a, w});
  endfunction

  // Scoreboard: every non-NOP command and every rd_valid must match the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (cmdq.size() > 0 && cmdq[0].cyc < cyc) begin
        ev_t m;
        m = cmdq.pop_front();
        fail("missing_cmd", 64'(m.cmd), 64'(m.cyc));
      end
      if (rdq.size() > 0 && rdq[0] < cyc) begin
        int mr;
        mr = rdq.pop_front();
        fail("missing_rd_valid", 64'(cyc), 64'(mr));
      end
      if (cmd != NOP) begin
        if (cmdq.size() == 0) fail("unexpected_cmd", 64'(cmd), 64'(NOP));
        else begin
          ev_t e;
          longint a, x;
          e = cmdq.pop_front();
          a = pack_ev(cyc, cmd, sd_ba, sd_addr, wr_done);
          x = pack_ev(e.cyc, e.cmd, e.ba, e.addr, e.wr);
          check(a == x, "cmd_seq{cyc,cmd,ba,addr,wr}", a, x);
        end
      end else begin
        check(sd_addr == 13'd0 && wr_done == 1'b0, "nop_addr_wr", 64'({wr_done, sd_addr}), 64'd0);
      end
      if (rd_valid) begin
        if (rdq.size() == 0) fail("unexpected_rd_valid", 64'(cyc), 64'd0);
        else begin
          int r;
          r = rdq.pop_front();
          check(r == cyc, "rd_valid_cycle", 64'(cyc), 64'(r));
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec[5];
    int   a, prev_a, guard, refs, misses, hits;

    vec[0] = '{1'b1, 1'b0, 1'b0, 2'd1, 13'h123,  9'h045, RD, 1, 3, 5,  5, 7};
    vec[1] = '{1'b1, 1'b0, 1'b1, 2'd1, 13'h123,  9'h045, WR, 1, 3, 5, -1, 7};
    vec[2] = '{1'b1, 1'b1, 1'b0, 2'd2, 13'h1FFF, 9'h1FF, RD, 1, 3, 5,  5, 7};
    vec[3] = '{1'b0, 1'b1, 1'b1, 2'd3, 13'h0000, 9'h000, WR, 1, 3, 5, -1, 7};
    vec[4] = '{1'b0, 1'b0, 1'b0, 2'd0, 13'h00AA, 9'h100, RD, 1, 3, 5,  5, 7};

    reset = 1'b1; rm_reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    r_valid = 1'b0; r_we = 1'b0; r_addr = '0;
    m_valid = 1'b0; m_we = 1'b0; m_addr = '0;
    prev_a = 0;

    do_reset();
    #1;
    check(cmd == NOP && sd_ba == 2'd0 && sd_addr == 13'd0, "reset_cmd_addr",
          64'({cmd, sd_ba, sd_addr}), 64'd0);
    check(!rd_valid && !wr_done && !ref_miss && !busy, "reset_pulses",
          64'({rd_valid, wr_done, ref_miss, busy}), 64'd0);
    check(req_ready == 1'b1, "reset_req_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 5; i++) begin
      if (vec[i].fresh) begin
        do_reset();
        while (cyc < 10) @(negedge clk);
      end
      req_we    = vec[i].we;
      req_addr  = {vec[i].ba, vec[i].row, vec[i].col};
      req_valid = 1'b1;
      guard = 0;
      while (!req_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!req_ready) begin
        fail("accept_timeout", 64'(guard), 64'd0);
        req_valid = 1'b0;
        break;
      end
      a = cyc;
      if (vec[i].fresh) check(a == 10, "accept_cycle", 64'(a), 64'd10);
      else              check(a == prev_a + 7, "b2b_act_spacing", 64'(a - prev_a), 64'd7);
      cmdq.push_back('{a + vec[i].exp_act, ACT, vec[i].ba, vec[i].row, 1'b0});
      cmdq.push_back('{a + vec[i].exp_rw, vec[i].exp_rw_cmd, vec[i].ba, 13'(vec[i].col), vec[i].we});
      cmdq.push_back('{a + vec[i].exp_pre, PRE, vec[i].ba, 13'd0, 1'b0});
      if (vec[i].exp_rdv > 0) rdq.push_back(a + vec[i].exp_rdv);
      prev_a = a;
      for (int k = 1; k <= vec[i].exp_ready; k++) begin
        @(negedge clk);
        if (k == 1) begin
          if (vec[i].b2b_next && i < 4) begin
            req_we   = vec[i+1].we;
            req_addr = {vec[i+1].ba, vec[i+1].row, vec[i+1].col};
          end else begin
            req_valid = 1'b0;
          end
        end
        if (k == vec[i].exp_ready - 1)
          check(!req_ready && busy, "busy_before_idle", 64'({req_ready, busy}), 64'b01);
        if (k == vec[i].exp_ready)
          check(req_ready && !busy, "ready_at_idle", 64'({req_ready, busy}), 64'b10);
      end
    end
    repeat (4) @(negedge clk);

    // Reset while waiting tRCD: sequence abandoned, no RD or PRE follows.
    do_reset();
    while (cyc < 10) @(negedge clk);
    req_we = 1'b0; req_addr = {2'd1, 13'h123, 9'h045}; req_valid = 1'b1;
    cmdq.push_back('{11, ACT, 2'd1, 13'h123, 1'b0});
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check(busy == 1'b1, "busy_in_wait_rcd", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check(cmd == NOP && busy == 1'b0 && rd_valid == 1'b0, "async_reset_outputs",
          64'({cmd, busy, rd_valid}), 64'd0);
    cmdq.delete();
    rdq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check(req_ready == 1'b1, "ready_after_reset", 64'(req_ready), 64'd1);
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (cmd != NOP) hits++;
    end
    check(hits == 0, "no_cmd_after_reset", 64'(hits), 64'd0);
    check(cmdq.size() == 0, "cmd_queue_drained", 64'(cmdq.size()), 64'd0);
    check(rdq.size() == 0, "rd_queue_drained", 64'(rdq.size()), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Refresh priority (T_REF=20) and missed refresh (T_REF=4) in parallel.
    @(negedge clk);
    rm_reset = 1'b0;
    #1;
    check(r_ready == 1'b1 && m_ref_miss == 1'b0, "rm_reset_state",
          64'({r_ready, m_ref_miss}), 64'b10);
    refs = 0; misses = 0;
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      if (k == 19) check(r_ready == 1'b1, "ready_before_expiry", 64'(r_ready), 64'd1);
      if (k == 20) begin
        r_we = 1'b0; r_addr = {2'd2, 13'h055, 9'h011}; r_valid = 1'b1;
      end
      if (k >= 20 && k <= 27)
        check(!r_ready && r_cmd != ACT, "ref_blocks_request", 64'({r_ready, r_cmd}), 64'(REF));
      if (k == 21) check(r_cmd == REF, "ref_issued", 64'(r_cmd), 64'(REF));
      if (k == 28) check(r_ready == 1'b1, "ready_after_rfc", 64'(r_ready), 64'd1);
      if (k == 29) begin
        check(r_cmd == ACT && r_sd_addr == 13'h055, "act_after_ref",
              64'({r_cmd, r_sd_addr}), 64'({ACT, 13'h055}));
        r_valid = 1'b0;
      end
      if (k == 41) check(r_cmd == REF, "second_ref", 64'(r_cmd), 64'(REF));
      if (k <= 32) begin
        logic       exp_ref, exp_miss;
        exp_ref  = (k == 5 || k == 13 || k == 21 || k == 29);
        exp_miss = (k == 12 || k == 20 || k == 28);
        check(m_cmd == (exp_ref ? REF : NOP), "miss_cmd", 64'(m_cmd), 64'(exp_ref ? REF : NOP));
        check(m_ref_miss == exp_miss, "ref_miss_pulse", 64'(m_ref_miss), 64'(exp_miss));
        if (m_cmd == REF) refs++;
        if (m_ref_miss) misses++;
      end
    end
    check(refs == 4, "ref_count", 64'(refs), 64'd4);
    check(misses == 3, "miss_count", 64'(misses), 64'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
